cim_gemv_sequencer: RTL
=======================

# cim_gemv_sequencer

Sequencer that runs an int8 matrix-vector product out of CIM SRAM. For each output row n it streams packed input words and weight words through the SRAM read port, accumulates a 4-lane signed int8 dot product, and writes one 32-bit result word back through the SRAM write port. It sits between the CIM controller's config/start registers and the SRAM ports, and raises done/err for the controller's IRQ logic.

## Interface
Parameters:
- ADDR_WIDTH, 17, SRAM word-address width
- ACC_WIDTH, 32, accumulator and result width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch request, sampled only in IDLE
- abort  in  1  synchronous cancel
- dim_n  in  16  output rows
- dim_kw  in  16  32-bit words per row (K/4)
- input_addr  in  ADDR_WIDTH  base word address of the input vector
- weight_addr  in  ADDR_WIDTH  base word address of the weights, row-major, dim_kw words per row
- output_addr  in  ADDR_WIDTH  base word address of the results
- rd_en  out  1  SRAM read strobe
- rd_addr  out  ADDR_WIDTH  read address
- rd_data  in  32  read data, valid the cycle after rd_en
- wr_en  out  1  SRAM write strobe
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  ACC_WIDTH  write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a rejected start

## Operation
- All config inputs are captured on an accepted start. Changes while busy are ignored.
- States: IDLE, RD_IN, RD_W, DRAIN, WRITE, DONE.
- IDLE:
  - start with dim_n=0 or dim_kw=0: err pulses the next cycle, no reads, the FSM stays in IDLE.
  - Any other start: clear acc, set k=0, n=0, wptr=weight_addr, go to RD_IN.
- RD_IN: rd_en=1, rd_addr=input_addr+k. Go to RD_W.
- RD_W:
  - rd_en=1, rd_addr=wptr. Register rd_data as in_word. Increment wptr.
  - If k==dim_kw-1, go to DRAIN. Otherwise k++ and go to RD_IN.
- Accumulate step: the weight word returns the cycle after RD_W, which is the next RD_IN or DRAIN. In that cycle, acc += dot(in_word, rd_data).
- DRAIN: performs the final accumulate. Go to WRITE.
- WRITE:
  - wr_en=1, wr_addr=output_addr+n, wr_data=acc.
  - Next cycle: acc=0, k=0.
  - If n==dim_n-1, go to DONE. Otherwise n++ and go to RD_IN.
- DONE: done=1 for one cycle. Go to IDLE.
- dot(): lane i is bits [8i+7:8i], i=0..3, signed int8. The four 16-bit signed products are sign-extended and summed. The accumulator wraps modulo 2^ACC_WIDTH, with no saturation.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- abort, in any state: go to IDLE on the next edge and clear acc. No further rd_en or wr_en, no done, no err. A write in progress on the abort cycle still completes.
- start while busy: ignored.
- rst: same effect as abort, plus clears all counters and pointers.

## Timing
- Reset values: rd_en=0, wr_en=0, busy=0, done=0, err=0, rd_addr=0, wr_addr=0, wr_data=0.
- All outputs are registered or decoded from state only. No combinational path from rd_data to any output.
- Start accepted at cycle 0:
  - First rd_en at cycle 1.
  - Each row takes 2·dim_kw+2 cycles.
  - done at cycle 1+dim_n·(2·dim_kw+2).
  - busy falls the cycle after done.
- Read port use: exactly one read per cycle during RD_IN/RD_W. Reads alternate input, weight. No bubbles inside a row.
- err is asserted at cycle 1 after a rejected start. busy stays 0.
- A new start is accepted in the first IDLE cycle after DONE.

## Test plan
- dim_n=1, dim_kw=1, input word 0x04030201, weight word 0x01010101:
  - reads at input_addr (cycle 1) then weight_addr (cycle 2)
  - wr_en at cycle 4 with wr_data=10 at output_addr
  - done at cycle 5
- Signed wrap check, input 0x80808080 × weight 0x7F7F7F7F: wr_data=0xFFFF0200 (−65024).
- dim_n=3, dim_kw=2, weight_addr=0x100:
  - weight reads 0x100..0x105 in order, input reads alternate input_addr, input_addr+1
  - writes at output_addr+0..2
  - done at cycle 19
- dim_kw=0 with start: err=1 at cycle 1, no rd_en, busy stays 0, no done.
- abort during row 2 of dim_n=3: busy=0 next cycle, no further writes, no done. A fresh start then yields correct row-0 results, proving acc was cleared.
- input_addr=0x1FFFF, dim_kw=2: second input read at address 0x00000. start pulsed while busy has no effect.

Source files
------------

// File: rtl/cim_gemv_sequencer.sv
// Int8 GEMV sequencer for CIM SRAM: per output row, alternates input/weight reads,
// accumulates a 4-lane signed dot product, then writes one result word.
module cim_gemv_sequencer #(
    parameter int ADDR_WIDTH = 17,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           dim_n,
    input  logic [15:0]           dim_kw,
    input  logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [ADDR_WIDTH-1:0] weight_addr,
    input  logic [ADDR_WIDTH-1:0] output_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ACC_WIDTH-1:0]  wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IN,
        S_RD_W,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           dim_n_q, dim_n_d;
    logic [15:0]           dim_kw_q, dim_kw_d;
    logic [ADDR_WIDTH-1:0] input_addr_q, input_addr_d;
    logic [ADDR_WIDTH-1:0] output_addr_q, output_addr_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [15:0]           k_q, k_d;
    logic [15:0]           n_q, n_d;
    logic [31:0]           in_word_q, in_word_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  acc_pend_q, acc_pend_d;
    logic                  err_q, err_d;

    function automatic logic [ACC_WIDTH-1:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [7:0]    la;
        logic signed [7:0]    lb;
        logic signed [15:0]   p;
        logic [ACC_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            la = a[8*i +: 8];
            lb = b[8*i +: 8];
            p  = la * lb;
            s  = s + {{(ACC_WIDTH-16){p[15]}}, p};
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dim_n_q       <= '0;
            dim_kw_q      <= '0;
            input_addr_q  <= '0;
            output_addr_q <= '0;
            wptr_q        <= '0;
            k_q           <= '0;
            n_q           <= '0;
            in_word_q     <= '0;
            acc_q         <= '0;
            acc_pend_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            dim_n_q       <= dim_n_d;
            dim_kw_q      <= dim_kw_d;
            input_addr_q  <= input_addr_d;
            output_addr_q <= output_addr_d;
            wptr_q        <= wptr_d;
            k_q           <= k_d;
            n_q           <= n_d;
            in_word_q     <= in_word_d;
            acc_q         <= acc_d;
            acc_pend_q    <= acc_pend_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dim_n_d       = dim_n_q;
        dim_kw_d      = dim_kw_q;
        input_addr_d  = input_addr_q;
        output_addr_d = output_addr_q;
        wptr_d        = wptr_q;
        k_d           = k_q;
        n_d           = n_q;
        in_word_d     = in_word_q;
        acc_d         = acc_q;
        acc_pend_d    = 1'b0;
        err_d         = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;

        // Weight word read in RD_W lands this cycle; fold it in against the latched input word.
        if (acc_pend_q) begin
            acc_d = acc_q + dot4(in_word_q, rd_data);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dim_n == 16'd0 || dim_kw == 16'd0) begin
                        err_d = 1'b1;
                    end else begin
                        dim_n_d       = dim_n;
                        dim_kw_d      = dim_kw;
                        input_addr_d  = input_addr;
                        output_addr_d = output_addr;
                        wptr_d        = weight_addr;
                        k_d           = '0;
                        n_d           = '0;
                        acc_d         = '0;
                        state_d       = S_RD_IN;
                    end
                end
            end
            S_RD_IN: begin
                rd_en   = 1'b1;
                rd_addr = input_addr_q + ADDR_WIDTH'(k_q);
                state_d = S_RD_W;
            end
            S_RD_W: begin
                rd_en      = 1'b1;
                rd_addr    = wptr_q;
                in_word_d  = rd_data;
                wptr_d     = wptr_q + ADDR_WIDTH'(1);
                acc_pend_d = 1'b1;
                if (k_q == dim_kw_q - 16'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + 16'd1;
                    state_d = S_RD_IN;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = output_addr_q + ADDR_WIDTH'(n_q);
                wr_data = acc_q;
                acc_d   = '0;
                k_d     = '0;
                if (n_q == dim_n_q - 16'd1) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 16'd1;
                    state_d = S_RD_IN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            acc_pend_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

endmodule
